state_dump_streamer: RTL and testbench

- Synthesizable, parametrised successor to bench-only register, CSR and RAM dump tasks.
- On a trigger (external pulse or a programmable periodic timer), it walks a configurable address window in each of NUM_CH storage channels through one shared synchronous read port.
- Each word read is emitted on a ready/valid stream tagged with channel, address and snapshot sequence number.
- Sits beside the core in SoC_TOP and feeds a trace/UART sink.

---
 rtl/dump_pkg.sv | 30 +++
 rtl/dump_period_timer.sv | 38 +++
 rtl/state_dump_streamer.sv | 243 ++++++++++++++++++++++++
 tb/tb_state_dump_streamer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared types for the state dump streamer.
//   dump_state_e : walker FSM states
//   ch_idx_w()   : channel-select width, at least one bit
//   dump_tag_t   : tag carried alongside each streamed word. The fields are sized for the
//                  largest supported configuration; users take the low bits they need.
package dump_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWait,
    StOut
  } dump_state_e;

  localparam int unsigned MaxChW   = 3;
  localparam int unsigned MaxAddrW = 32;
  localparam int unsigned MaxSeqW  = 32;

  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  typedef struct packed {
    logic [MaxChW-1:0]   ch;
    logic [MaxAddrW-1:0] addr;
    logic [MaxSeqW-1:0]  seq;
    logic                last;
  } dump_tag_t;

endpackage

// File: rtl/dump_period_timer.sv
// Free-running interval timer producing the periodic snapshot trigger.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_period       : interval in cycles, 0 disables ticking
//   o_tick         : one-cycle pulse when the count reaches i_period-1
// Any change of i_period restarts the count from 0.
module dump_period_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q;
  logic                changed;

  always_comb begin
    changed = (i_period != period_q);
    o_tick  = !changed && (period_q != '0) && (cnt_q == period_q - PERIOD_W'(1));
    cnt_d   = cnt_q + PERIOD_W'(1);
    if (changed || (period_q == '0) || o_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= i_period;
    end
  end

endmodule

// File: rtl/state_dump_streamer.sv
// Snapshot streamer: on a trigger (pulse or periodic tick) walks each channel's address
// window through one shared synchronous read port and streams every word with its tags.
//   i_trigger / i_period          : snapshot requests
//   i_ch_base / i_ch_limit        : packed per-channel windows [base, limit)
//   o_rd_en/o_rd_ch/o_rd_addr     : read port, i_rd_data returns one cycle later
//   o_dump_*, i_dump_ready        : ready/valid output stream with ch/addr/seq/last tags
//   o_busy, o_done, o_dropped     : status
module state_dump_streamer
  import dump_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned SEQ_W    = 16,
  localparam int unsigned CH_W    = ch_idx_w(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_trigger,
  input  logic [PERIOD_W-1:0]      i_period,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_limit,
  output logic                     o_rd_en,
  output logic [CH_W-1:0]          o_rd_ch,
  output logic [ADDR_W-1:0]        o_rd_addr,
  input  logic [XLEN-1:0]          i_rd_data,
  output logic                     o_dump_valid,
  input  logic                     i_dump_ready,
  output logic [XLEN-1:0]          o_dump_data,
  output logic [CH_W-1:0]          o_dump_ch,
  output logic [ADDR_W-1:0]        o_dump_addr,
  output logic [SEQ_W-1:0]         o_dump_seq,
  output logic                     o_dump_last,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [7:0]               o_dropped
);

  dump_state_e       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, nxt_ch_q, nxt_ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d, limit_q, limit_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [7:0]        dropped_q, dropped_d;
  logic [XLEN-1:0]   data_q, data_d;
  dump_tag_t         tag_q, tag_d;
  logic              pending_q, pending_d, valid_q, valid_d, done_q, done_d;
  logic              more_q, more_d, nxt_found_q, nxt_found_d;

  logic              tick, trig, start_req, hs, consume, more_now;
  logic [ADDR_W-1:0] base_a [NUM_CH];
  logic [ADDR_W-1:0] lim_a  [NUM_CH];
  logic              first_found, scan_found;
  logic [CH_W-1:0]   first_ch, scan_ch;

  dump_period_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_period(i_period),
    .o_tick  (tick)
  );

  assign trig      = i_trigger | tick;
  assign start_req = trig | pending_q;
  assign hs        = valid_q & i_dump_ready;
  assign more_now  = ({1'b0, addr_q} + (ADDR_W + 1)'(1)) < {1'b0, limit_q};

  // Descending scan so the lowest qualifying channel is the one left assigned.
  // first_*: first non-empty channel overall; scan_*: first non-empty after ch_q.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    scan_found  = 1'b0;
    scan_ch     = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      base_a[c] = i_ch_base[c*ADDR_W +: ADDR_W];
      lim_a[c]  = i_ch_limit[c*ADDR_W +: ADDR_W];
      if (base_a[c] < lim_a[c]) begin
        first_found = 1'b1;
        first_ch    = CH_W'(c);
        if (c > int'(ch_q)) begin
          scan_found = 1'b1;
          scan_ch    = CH_W'(c);
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_req && first_found) state_d = StRd;
      StRd:    state_d = StWait;
      StWait:  state_d = StOut;
      StOut: begin
        if (hs) begin
          if (more_q || nxt_found_q || (pending_q && first_found)) state_d = StRd;
          else state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: cursor, output register, sequence, pending/drop bookkeeping.
  always_comb begin
    ch_d        = ch_q;
    addr_d      = addr_q;
    limit_d     = limit_q;
    seq_d       = seq_q;
    dropped_d   = dropped_q;
    data_d      = data_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    more_d      = more_q;
    nxt_found_d = nxt_found_q;
    nxt_ch_d    = nxt_ch_q;
    consume     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          consume = pending_q;
          if (first_found) begin
            ch_d    = first_ch;
            addr_d  = base_a[first_ch];
            limit_d = lim_a[first_ch];
          end else begin
            done_d = 1'b1;
            seq_d  = seq_q + SEQ_W'(1);
          end
        end
      end
      StWait: begin
        // Decide the successor now so the last flag and the later advance always agree.
        valid_d                   = 1'b1;
        data_d                    = i_rd_data;
        more_d                    = more_now;
        nxt_found_d               = scan_found;
        nxt_ch_d                  = scan_ch;
        tag_d                     = '0;
        tag_d.ch[CH_W-1:0]        = ch_q;
        tag_d.addr[ADDR_W-1:0]    = addr_q;
        tag_d.seq[SEQ_W-1:0]      = seq_q;
        tag_d.last                = !more_now && !scan_found;
      end
      StOut: begin
        if (hs) begin
          valid_d = 1'b0;
          if (more_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end else if (nxt_found_q) begin
            ch_d    = nxt_ch_q;
            addr_d  = base_a[nxt_ch_q];
            limit_d = lim_a[nxt_ch_q];
          end else begin
            done_d = 1'b1;
            seq_d  = seq_q + SEQ_W'(1);
            // An all-empty pending request stays queued and completes from idle.
            if (pending_q && first_found) begin
              consume = 1'b1;
              ch_d    = first_ch;
              addr_d  = base_a[first_ch];
              limit_d = lim_a[first_ch];
            end
          end
        end
      end
      default: ;
    endcase

    pending_d = pending_q & ~consume;
    // A trigger that does not directly start a snapshot from idle is queued or dropped.
    if (trig && !(state_q == StIdle && !pending_q)) begin
      if (pending_d) begin
        if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ch_q        <= '0;
      addr_q      <= '0;
      limit_q     <= '0;
      seq_q       <= '0;
      dropped_q   <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      pending_q   <= 1'b0;
      more_q      <= 1'b0;
      nxt_found_q <= 1'b0;
      nxt_ch_q    <= '0;
    end else begin
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      limit_q     <= limit_d;
      seq_q       <= seq_d;
      dropped_q   <= dropped_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      pending_q   <= pending_d;
      more_q      <= more_d;
      nxt_found_q <= nxt_found_d;
      nxt_ch_q    <= nxt_ch_d;
    end
  end

  // Outputs.
  always_comb begin
    o_rd_en      = (state_q == StRd);
    o_rd_ch      = ch_q;
    o_rd_addr    = addr_q;
    o_dump_valid = valid_q;
    o_dump_data  = data_q;
    o_dump_ch    = tag_q.ch[CH_W-1:0];
    o_dump_addr  = tag_q.addr[ADDR_W-1:0];
    o_dump_seq   = tag_q.seq[SEQ_W-1:0];
    o_dump_last  = tag_q.last;
    o_busy       = (state_q != StIdle);
    o_done       = done_q;
    o_dropped    = dropped_q;
  end

  // Tag fields are wider than this configuration needs.
  logic unused_tag;
  assign unused_tag = ^tag_q;

endmodule

// File: tb/tb_state_dump_streamer.sv
module tb_state_dump_streamer;
  import dump_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned PERIOD_W = 24;
  localparam int unsigned SEQ_W    = 16;
  localparam int unsigned CH_W     = ch_idx_w(NUM_CH);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     trigger = 1'b0;
  logic [PERIOD_W-1:0]      period = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_base = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_limit = '0;
  logic                     rd_en;
  logic [CH_W-1:0]          rd_ch;
  logic [ADDR_W-1:0]        rd_addr;
  logic [XLEN-1:0]          rd_data = '0;
  logic                     dvalid;
  logic                     ready = 1'b1;
  logic [XLEN-1:0]          ddata;
  logic [CH_W-1:0]          dch;
  logic [ADDR_W-1:0]        daddr;
  logic [SEQ_W-1:0]         dseq;
  logic                     dlast, busy, done;
  logic [7:0]               dropped;

  state_dump_streamer #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .SEQ_W(SEQ_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trigger(trigger), .i_period(period),
    .i_ch_base(ch_base), .i_ch_limit(ch_limit),
    .o_rd_en(rd_en), .o_rd_ch(rd_ch), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_dump_valid(dvalid), .i_dump_ready(ready), .o_dump_data(ddata),
    .o_dump_ch(dch), .o_dump_addr(daddr), .o_dump_seq(dseq), .o_dump_last(dlast),
    .o_busy(busy), .o_done(done), .o_dropped(dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Storage model: every (channel, address) holds a distinct word; idle cycles return noise.
  logic [31:0] salt;
  function automatic logic [31:0] memf(input int c, input int a);
    logic [31:0] cc, aa;
    cc = 32'(c);
    aa = 32'(a);
    return salt ^ (cc * 32'h9E37_79B1) ^ (aa << 7) ^ aa;
  endfunction

  always @(posedge clk) rd_data <= rd_en ? memf(int'(rd_ch), int'(rd_addr)) : $urandom();

  // Reference: a snapshot is every address of every non-empty window, channel order.
  typedef struct {int ch; int addr; int seq; bit last;} exp_t;
  exp_t expq[$];
  int   exp_seq = 0;
  int   wb[NUM_CH];
  int   wl[NUM_CH];

  task automatic apply_windows();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_base[c*ADDR_W +: ADDR_W]  = ADDR_W'(wb[c]);
      ch_limit[c*ADDR_W +: ADDR_W] = ADDR_W'(wl[c]);
    end
  endtask

  task automatic expect_snapshot(output int total);
    int k;
    exp_t e;
    total = 0;
    for (int c = 0; c < NUM_CH; c++) if (wl[c] > wb[c]) total += wl[c] - wb[c];
    k = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int a = wb[c]; a < wl[c]; a++) begin
        e.ch = c; e.addr = a; e.seq = exp_seq; e.last = (k == total - 1);
        expq.push_back(e);
        k++;
      end
    end
    exp_seq = (exp_seq + 1) % (1 << SEQ_W);
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  int   cyc = 0;
  int   words = 0, done_cnt = 0, busy_rises = 0;
  int   acc_cyc[$];
  int   start_cyc[$];
  logic busy_prev = 1'b0, hold_v = 1'b0, hold_last = 1'b0;
  logic [XLEN-1:0]   hold_data = '0;
  logic [CH_W-1:0]   hold_ch = '0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [SEQ_W-1:0]  hold_seq = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v    <= 1'b0;
      busy_prev <= 1'b0;
    end else begin
      if (hold_v) begin
        check_eq("stall_valid", 64'(dvalid), 64'd1);
        check_eq("stall_data", 64'(ddata), 64'(hold_data));
        check_eq("stall_tag", {dch, daddr, dseq, dlast}, {hold_ch, hold_addr, hold_seq, hold_last});
      end
      if (dvalid && ready) begin
        check_eq("word_expected", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          exp_t e;
          e = expq.pop_front();
          check_eq("word_ch", 64'(dch), 64'(e.ch));
          check_eq("word_addr", 64'(daddr), 64'(e.addr));
          check_eq("word_seq", 64'(dseq), 64'(e.seq));
          check_eq("word_last", 64'(dlast), 64'(e.last));
          check_eq("word_data", 64'(ddata), 64'(memf(e.ch, e.addr)));
        end
        words <= words + 1;
        acc_cyc.push_back(cyc);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy && !busy_prev) begin
        busy_rises <= busy_rises + 1;
        start_cyc.push_back(cyc);
      end
      busy_prev <= busy;
      hold_v    <= dvalid && !ready;
      hold_data <= ddata;
      hold_ch   <= dch;
      hold_addr <= daddr;
      hold_seq  <= dseq;
      hold_last <= dlast;
    end
  end

  // Sink ready: 0 = always ready, 1 = 0/1 every two cycles, 2 = random.
  int         rmode = 0;
  logic [1:0] rphase = '0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       ready = 1'b1;
      1:       begin ready = rphase[1]; rphase = rphase + 2'd1; end
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    trigger = 1'b0;
    period  = '0;
    expq.delete();
    exp_seq = 0;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic pulse();
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check_eq({tag, "_done_in_time"}, 64'(done_cnt >= target), 64'd1);
    step(3);
    check_eq({tag, "_queue_drained"}, 64'(expq.size()), 64'd0);
  endtask

  task automatic set_win(input int c, input int b, input int l);
    wb[c] = b;
    wl[c] = l;
  endtask

  int tot, d0, w0, a0, r0, s0, n;

  initial begin
    salt = $urandom();
    step(1);
    rst_n = 1'b0;
    step(2);
    check_eq("rst_valid", 64'(dvalid), 64'd0);
    check_eq("rst_rd_en", 64'(rd_en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dropped", 64'(dropped), 64'd0);
    check_eq("rst_tag", {dch, daddr, dseq, dlast, ddata}, 64'd0);

    // Basic walk with exact timing.
    do_reset();
    rmode = 0;
    set_win(0, 0, 4); set_win(1, 0, 2); set_win(2, 10, 12);
    apply_windows();
    expect_snapshot(tot);
    a0 = acc_cyc.size(); d0 = done_cnt; w0 = words;
    pulse();
    check_eq("t1_rd_en_c0", 64'(rd_en), 64'd1);
    check_eq("t1_rd_cursor", {rd_ch, rd_addr}, 64'd0);
    check_eq("t1_busy", 64'(busy), 64'd1);
    step(1);
    check_eq("t1_rd_en_c1", 64'(rd_en), 64'd0);
    check_eq("t1_valid_c1", 64'(dvalid), 64'd0);
    step(1);
    check_eq("t1_valid_c2", 64'(dvalid), 64'd1);
    wait_done("t1", d0 + 1, 200);
    check_eq("t1_words", 64'(words - w0), 64'(tot));
    check_eq("t1_done_once", 64'(done_cnt - d0), 64'd1);
    check_eq("t1_idle", 64'(busy), 64'd0);
    if (acc_cyc.size() >= a0 + 8)
      for (int i = 1; i < 8; i++)
        check_eq("t1_spacing", 64'(acc_cyc[a0+i] - acc_cyc[a0+i-1]), 64'd3);

    // Random windows under backpressure.
    for (int it = 0; it < 8; it++) begin
      rmode = (it < 4) ? 1 : 2;
      for (int c = 0; c < NUM_CH; c++) begin
        wb[c] = $urandom_range(0, 8);
        wl[c] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : wb[c] + $urandom_range(0, 4);
      end
      apply_windows();
      expect_snapshot(tot);
      d0 = done_cnt; w0 = words;
      pulse();
      wait_done("t2", d0 + 1, 300);
      check_eq("t2_words", 64'(words - w0), 64'(tot));
    end
    rmode = 0;

    // Periodic trigger.
    do_reset();
    set_win(0, 0, 2); set_win(1, 3, 4); set_win(2, 7, 8);
    apply_windows();
    for (int i = 0; i < 3; i++) expect_snapshot(tot);
    s0 = start_cyc.size(); d0 = done_cnt;
    period = PERIOD_W'(50);
    wait_done("t3", d0 + 3, 400);
    period = '0;
    check_eq("t3_starts", 64'(start_cyc.size() >= s0 + 3), 64'd1);
    if (start_cyc.size() >= s0 + 3) begin
      check_eq("t3_interval_a", 64'(start_cyc[s0+1] - start_cyc[s0]), 64'd50);
      check_eq("t3_interval_b", 64'(start_cyc[s0+2] - start_cyc[s0+1]), 64'd50);
    end
    check_eq("t3_dropped", 64'(dropped), 64'd0);

    // Pending and dropped triggers.
    do_reset();
    set_win(0, 0, 5); set_win(1, 2, 7); set_win(2, 0, 0);
    apply_windows();
    expect_snapshot(tot);
    expect_snapshot(tot);
    d0 = done_cnt; r0 = busy_rises; w0 = words;
    trigger = 1'b1; step(1);
    trigger = 1'b0; step(1);
    trigger = 1'b1; step(2);
    trigger = 1'b0;
    wait_done("t4", d0 + 2, 400);
    check_eq("t4_dropped", 64'(dropped), 64'd1);
    check_eq("t4_back_to_back", 64'(busy_rises - r0), 64'd1);
    check_eq("t4_words", 64'(words - w0), 64'd20);

    // Skipped and all-empty channels.
    do_reset();
    set_win(0, 0, 2); set_win(1, 5, 5); set_win(2, 3, 4);
    apply_windows();
    expect_snapshot(tot);
    d0 = done_cnt;
    pulse();
    wait_done("t5a", d0 + 1, 200);
    set_win(0, 5, 5); set_win(1, 3, 0); set_win(2, 1, 1);
    apply_windows();
    expect_snapshot(tot);
    d0 = done_cnt; w0 = words; r0 = busy_rises;
    pulse();
    wait_done("t5b", d0 + 1, 50);
    check_eq("t5_empty_words", 64'(words - w0), 64'd0);
    check_eq("t5_empty_busy", 64'(busy_rises - r0), 64'd0);
    set_win(0, 2, 3); set_win(1, 0, 0); set_win(2, 0, 0);
    apply_windows();
    expect_snapshot(tot);
    d0 = done_cnt;
    pulse();
    wait_done("t5c", d0 + 1, 200);

    // Reset in the middle of a snapshot.
    do_reset();
    set_win(0, 0, 4); set_win(1, 0, 2); set_win(2, 10, 12);
    apply_windows();
    expect_snapshot(tot);
    w0 = words;
    pulse();
    n = 0;
    while (!(words >= w0 + 2 && dvalid) && n < 100) begin
      step(1);
      n++;
    end
    check_eq("t6_reached_word3", 64'(words >= w0 + 2 && dvalid), 64'd1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_valid_cleared", 64'(dvalid), 64'd0);
    check_eq("t6_busy_cleared", 64'(busy), 64'd0);
    check_eq("t6_rd_en_cleared", 64'(rd_en), 64'd0);
    expq.delete();
    exp_seq = 0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check_eq("t6_no_done", 64'(done_cnt - d0), 64'd0);
    expect_snapshot(tot);
    d0 = done_cnt;
    pulse();
    wait_done("t6", d0 + 1, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
